// File: rtl/fft_pkg.sv
// Shared constants and FSM encoding for the FFT peak detector.
package fft_pkg;

   localparam int FFT_N      = 512;
   localparam int FFT_DATA_W = 16;
   localparam int FFT_IDX_W  = 9;
   localparam int FFT_PWR_W  = 2*FFT_DATA_W;

   typedef enum logic {
      ST_IDLE   = 1'b0,
      ST_ACTIVE = 1'b1
   } fft_state_e;

endpackage

// File: rtl/fft_peak_detect_if.sv
// Avalon-ST source bus from the FFT core into the peak detector.
interface fft_peak_detect_if import fft_pkg::*; #(
   parameter int DATA_W = FFT_DATA_W
);
   logic                     source_valid;
   logic                     source_sop;
   logic                     source_eop;
   logic signed [DATA_W-1:0] source_real;
   logic signed [DATA_W-1:0] source_imag;
   logic                     source_ready;

   modport master (
      output source_valid, source_sop, source_eop, source_real, source_imag,
      input  source_ready
   );

   modport slave (
      input  source_valid, source_sop, source_eop, source_real, source_imag,
      output source_ready
   );
endinterface

// File: rtl/fft_pwr_calc.sv
// Bin power pipeline: squares registered on the accepting edge, the sum is
// formed combinationally from those registers so the consumer can compare
// and register the result on the following edge. A sideband word rides
// alongside so framing information stays aligned with its power value.
module fft_pwr_calc import fft_pkg::*; #(
   parameter int DATA_W = FFT_DATA_W,
   parameter int SB_W   = 4
) (
   input  logic                     clk,
   input  logic                     rst_n,
   input  logic                     in_valid,
   input  logic signed [DATA_W-1:0] in_re,
   input  logic signed [DATA_W-1:0] in_im,
   input  logic [SB_W-1:0]          in_sb,
   output logic                     out_valid,
   output logic [2*DATA_W-1:0]      out_pwr,
   output logic [SB_W-1:0]          out_sb
);

   logic signed [2*DATA_W-1:0] re_ext;
   logic signed [2*DATA_W-1:0] im_ext;
   logic signed [2*DATA_W-1:0] re_sq_s;
   logic signed [2*DATA_W-1:0] im_sq_s;
   logic        [2*DATA_W-1:0] re_sq_q;
   logic        [2*DATA_W-1:0] im_sq_q;
   logic                       valid_q;
   logic        [SB_W-1:0]     sb_q;

   // Full-width signed squares; the largest is 2^(2*DATA_W-2), so no wrap.
   assign re_ext  = {{DATA_W{in_re[DATA_W-1]}}, in_re};
   assign im_ext  = {{DATA_W{in_im[DATA_W-1]}}, in_im};
   assign re_sq_s = re_ext * re_ext;
   assign im_sq_s = im_ext * im_ext;

   // Stage 1: capture squares and sideband for the accepted beat.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         re_sq_q <= '0;
         im_sq_q <= '0;
         valid_q <= 1'b0;
         sb_q    <= '0;
      end else begin
         valid_q <= in_valid;
         if (in_valid) begin
            re_sq_q <= re_sq_s;
            im_sq_q <= im_sq_s;
            sb_q    <= in_sb;
         end
      end
   end

   // Stage 2 adder: sum of two non-negative squares fits 2*DATA_W unsigned.
   assign out_pwr   = re_sq_q + im_sq_q;
   assign out_valid = valid_q;
   assign out_sb    = sb_q;

endmodule

// File: rtl/fft_peak_detect.sv
// Tracks the maximum-power bin across one FFT frame and reports it with a
// one-cycle strobe two cycles after the eop beat; malformed frames raise
// frame_err instead. Build option FFT_HALF_SPECTRUM_EN restricts the compare
// to the lower half of the spectrum while framing still counts every bin.
//
// state     | meaning
// ----------+---------------------------------------------------------
// ST_IDLE   | waiting for sop; non-sop beats are dropped
// ST_ACTIVE | inside a frame; bin_q is the index of the next beat
module fft_peak_detect import fft_pkg::*; #(
   parameter int DATA_W   = FFT_DATA_W,
   parameter int N_POINTS = FFT_N,
   parameter int IDX_W    = FFT_IDX_W
) (
   input  logic                clk,
   input  logic                rst_n,
   fft_peak_detect_if.slave    src,
   output logic [IDX_W-1:0]    peak_idx,
   output logic [2*DATA_W-1:0] peak_pwr,
   output logic                peak_valid,
   output logic                frame_err
);

   localparam int PWR_W = 2*DATA_W;
   localparam int SB_W  = IDX_W + 4;
   localparam logic [IDX_W-1:0] LAST_BIN = IDX_W'(N_POINTS-1);

   fft_state_e       state_q, state_d;
   logic [IDX_W-1:0] bin_q, bin_d;
   logic             ready_q;
   logic             accept;

   // Per-beat tag handed to the power pipeline.
   logic             tag_v;
   logic [IDX_W-1:0] tag_idx;
   logic             tag_first;
   logic             tag_last;
   logic             tag_err;
   logic             tag_cmp;

   logic             p_valid;
   logic [PWR_W-1:0] p_pwr;
   logic [SB_W-1:0]  p_sb;
   logic [IDX_W-1:0] p_idx;
   logic             p_first, p_last, p_err, p_cmp;

   logic [PWR_W-1:0] max_pwr_q;
   logic [IDX_W-1:0] max_idx_q;
   logic             in_range;
   logic             take;
   logic [PWR_W-1:0] best_pwr;
   logic [IDX_W-1:0] best_idx;

   assign src.source_ready = ready_q;
   assign accept           = src.source_valid & ready_q;

   // Ready comes up on the first edge after reset release.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) ready_q <= 1'b0;
      else        ready_q <= 1'b1;
   end

   // FSM state and bin counter registers.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= ST_IDLE;
         bin_q   <= '0;
      end else begin
         state_q <= state_d;
         bin_q   <= bin_d;
      end
   end

   // Framing decisions for the accepted beat and the tag it carries.
   always_comb begin
      state_d   = state_q;
      bin_d     = bin_q;
      tag_v     = 1'b0;
      tag_idx   = bin_q;
      tag_first = 1'b0;
      tag_last  = 1'b0;
      tag_err   = 1'b0;
      tag_cmp   = 1'b0;
      if (accept) begin
         case (state_q)
            ST_IDLE: begin
               if (src.source_sop) begin
                  tag_v = 1'b1;
                  if (src.source_eop) begin
                     tag_err = 1'b1;
                  end else begin
                     tag_idx   = '0;
                     tag_first = 1'b1;
                     tag_cmp   = 1'b1;
                     bin_d     = IDX_W'(1);
                     state_d   = ST_ACTIVE;
                  end
               end
            end
            ST_ACTIVE: begin
               tag_v = 1'b1;
               if (src.source_sop) begin
                  // Aborts the running frame; a clean sop restarts at bin 0.
                  tag_err = 1'b1;
                  if (src.source_eop) begin
                     bin_d   = '0;
                     state_d = ST_IDLE;
                  end else begin
                     tag_idx   = '0;
                     tag_first = 1'b1;
                     tag_cmp   = 1'b1;
                     bin_d     = IDX_W'(1);
                  end
               end else begin
                  tag_cmp = 1'b1;
                  if (src.source_eop || bin_q == LAST_BIN) begin
                     if (src.source_eop && bin_q == LAST_BIN) tag_last = 1'b1;
                     else                                     tag_err  = 1'b1;
                     bin_d   = '0;
                     state_d = ST_IDLE;
                  end else begin
                     bin_d = bin_q + IDX_W'(1);
                  end
               end
            end
            default: begin
               bin_d   = '0;
               state_d = ST_IDLE;
            end
         endcase
      end
   end

   fft_pwr_calc #(
      .DATA_W (DATA_W),
      .SB_W   (SB_W)
   ) u_pwr_calc (
      .clk       (clk),
      .rst_n     (rst_n),
      .in_valid  (tag_v),
      .in_re     (src.source_real),
      .in_im     (src.source_imag),
      .in_sb     ({tag_idx, tag_first, tag_last, tag_err, tag_cmp}),
      .out_valid (p_valid),
      .out_pwr   (p_pwr),
      .out_sb    (p_sb)
   );

   assign {p_idx, p_first, p_last, p_err, p_cmp} = p_sb;

`ifdef FFT_HALF_SPECTRUM_EN
   assign in_range = (p_idx < IDX_W'(N_POINTS/2));
`else
   assign in_range = 1'b1;
`endif

   // Strict greater-than keeps the earliest bin on ties; first bin always loads.
   always_comb begin
      take     = p_valid & p_cmp & in_range & (p_first | (p_pwr > max_pwr_q));
      best_pwr = max_pwr_q;
      best_idx = max_idx_q;
      if (take) begin
         best_pwr = p_pwr;
         best_idx = p_idx;
      end
   end

   // Running max and result strobes; err and last never share a beat.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         max_pwr_q  <= '0;
         max_idx_q  <= '0;
         peak_idx   <= '0;
         peak_pwr   <= '0;
         peak_valid <= 1'b0;
         frame_err  <= 1'b0;
      end else begin
         max_pwr_q  <= best_pwr;
         max_idx_q  <= best_idx;
         peak_valid <= p_valid & p_last;
         frame_err  <= p_valid & p_err;
         if (p_valid && p_last) begin
            peak_idx <= best_idx;
            peak_pwr <= best_pwr;
         end
      end
   end

endmodule

// File: tb/tb_fft_peak_detect.sv
// Scoreboard bench for fft_peak_detect: expected events are queued as beats
// are driven and retired when peak_valid or frame_err fires.
module tb_fft_peak_detect;
   import fft_pkg::*;

`ifdef FFT_HALF_SPECTRUM_EN
   localparam int CMP_BINS = FFT_N/2;
`else
   localparam int CMP_BINS = FFT_N;
`endif

   typedef struct {
      bit     is_err;
      int     idx;
      longint pwr;
      int     dcyc;
   } exp_t;

   logic                   clk;
   logic                   rst_n;
   logic [FFT_IDX_W-1:0]   peak_idx;
   logic [FFT_PWR_W-1:0]   peak_pwr;
   logic                   peak_valid;
   logic                   frame_err;

   fft_peak_detect_if #(.DATA_W(FFT_DATA_W)) bus ();

   fft_peak_detect dut (
      .clk        (clk),
      .rst_n      (rst_n),
      .src        (bus),
      .peak_idx   (peak_idx),
      .peak_pwr   (peak_pwr),
      .peak_valid (peak_valid),
      .frame_err  (frame_err)
   );

   int   n_tests = 0;
   int   n_fail  = 0;
   int   cyc     = 0;
   exp_t sb_q[$];
   bit   tb_active = 0;
   int   fr_re[FFT_N];
   int   fr_im[FFT_N];

   initial clk = 1'b0;
   always #5 clk = ~clk;

   always @(posedge clk) cyc <= cyc + 1;

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      n_tests++;
      if (obs !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
      end
   endtask

   // Retire one scoreboard entry per output strobe.
   always @(negedge clk) begin
      exp_t e;
      if (rst_n && (peak_valid || frame_err)) begin
         chk("pv_fe_excl", 64'(peak_valid & frame_err), 64'd0);
         if (sb_q.size() == 0) begin
            chk("spurious_evt", 64'(sb_q.size()), 64'd1);
         end else begin
            e = sb_q.pop_front();
            chk("evt_kind", 64'(frame_err), 64'(e.is_err));
            chk("evt_latency", 64'(cyc - e.dcyc), 64'd2);
            if (!e.is_err && peak_valid) begin
               chk("peak_idx", 64'(peak_idx), 64'(e.idx));
               chk("peak_pwr", 64'(peak_pwr), 64'(e.pwr));
            end
         end
      end
   end

   function automatic void clear_frame();
      for (int i = 0; i < FFT_N; i++) begin
         fr_re[i] = 0;
         fr_im[i] = 0;
      end
   endfunction

   function automatic void model_peak(output int idx, output longint pwr);
      longint p;
      idx = 0;
      pwr = -1;
      for (int i = 0; i < CMP_BINS; i++) begin
         p = longint'(fr_re[i]) * fr_re[i] + longint'(fr_im[i]) * fr_im[i];
         if (p > pwr) begin
            pwr = p;
            idx = i;
         end
      end
   endfunction

   task automatic drive_beat(input int re, input int im, input bit sop, input bit eop,
                             input int gap, output int dcyc);
      @(negedge clk);
      while (gap > 0 && $urandom_range(0, 99) < gap) begin
         bus.source_valid = 1'b0;
         @(negedge clk);
      end
      bus.source_valid = 1'b1;
      bus.source_sop   = sop;
      bus.source_eop   = eop;
      bus.source_real  = 16'(re);
      bus.source_imag  = 16'(im);
      dcyc = cyc;
   endtask

   task automatic push_err(input int dc);
      exp_t e;
      e.is_err = 1'b1;
      e.idx    = 0;
      e.pwr    = 0;
      e.dcyc   = dc;
      sb_q.push_back(e);
   endtask

   task automatic send_frame(input int nbins, input bit with_eop, input int gap);
      int   dc;
      bit   sop;
      bit   eop;
      exp_t e;
      for (int i = 0; i < nbins; i++) begin
         sop = (i == 0);
         eop = with_eop && (i == nbins-1);
         drive_beat(fr_re[i], fr_im[i], sop, eop, (i == 0) ? 0 : gap, dc);
         if (sop && tb_active) push_err(dc);
         tb_active = 1'b1;
         if (eop) begin
            tb_active = 1'b0;
            if (nbins == FFT_N) begin
               model_peak(e.idx, e.pwr);
               e.is_err = 1'b0;
               e.dcyc   = dc;
               sb_q.push_back(e);
            end else begin
               push_err(dc);
            end
         end
      end
   endtask

   task automatic drain();
      @(negedge clk);
      bus.source_valid = 1'b0;
      for (int i = 0; i < 12 && sb_q.size() > 0; i++) @(negedge clk);
      chk("drain", 64'(sb_q.size()), 64'd0);
   endtask

   initial begin
      #2_000_000;
      $display("FAIL watchdog: got timeout expected finish");
      $fatal(1, "watchdog");
   end

   initial begin
      int dc;
      rst_n            = 1'b0;
      bus.source_valid = 1'b0;
      bus.source_sop   = 1'b0;
      bus.source_eop   = 1'b0;
      bus.source_real  = '0;
      bus.source_imag  = '0;
      repeat (3) @(negedge clk);
      chk("rst_ready", 64'(bus.source_ready), 64'd0);
      chk("rst_pv",    64'(peak_valid), 64'd0);
      chk("rst_fe",    64'(frame_err), 64'd0);
      chk("rst_idx",   64'(peak_idx), 64'd0);
      chk("rst_pwr",   64'(peak_pwr), 64'd0);
      rst_n = 1'b1;
      @(negedge clk);
      chk("ready_up", 64'(bus.source_ready), 64'd1);

      // Single peak at bin 37: 100^2 + 200^2 = 50000.
      clear_frame();
      fr_re[37] = 100;
      fr_im[37] = -200;
      send_frame(FFT_N, 1'b1, 0);

      // Tie at full scale, sent back-to-back: lower bin wins, 2^31.
      clear_frame();
      fr_re[10]  = -32768; fr_im[10]  = -32768;
      fr_re[300] = -32768; fr_im[300] = -32768;
      send_frame(FFT_N, 1'b1, 0);
      drain();

      // Short frame ending at bin 200, then a good frame.
      clear_frame();
      send_frame(201, 1'b1, 0);
      fr_re[77] = 1234; fr_im[77] = 5;
      send_frame(FFT_N, 1'b1, 0);
      drain();

      // Frame aborted by sop where bin 100 was due, then peak at bin 5.
      clear_frame();
      fr_re[50] = 3000;
      send_frame(100, 1'b0, 0);
      clear_frame();
      fr_re[5] = -700; fr_im[5] = 300;
      send_frame(FFT_N, 1'b1, 0);
      drain();

      // Back-to-back frames with ~30% idle gaps, peaks at 3 then 400.
      clear_frame();
      fr_re[3] = 900; fr_im[3] = 900;
      send_frame(FFT_N, 1'b1, 30);
      clear_frame();
      fr_re[400] = -20000; fr_im[400] = 15000;
      fr_re[7]   = 10;
      send_frame(FFT_N, 1'b1, 30);
      drain();

      // Largest at 400, second at 100: result depends on half-spectrum build.
      clear_frame();
      fr_re[400] = 1000; fr_im[400] = 1000;
      fr_re[100] = 500;
      send_frame(FFT_N, 1'b1, 0);
      drain();

      // All-zero frame reports bin 0, power 0.
      clear_frame();
      send_frame(FFT_N, 1'b1, 0);
      drain();

      // Stray non-sop beat in idle is dropped; sop+eop beat is an error.
      drive_beat(40, 40, 1'b0, 1'b0, 0, dc);
      drive_beat(40, 40, 1'b1, 1'b1, 0, dc);
      push_err(dc);
      drain();

      // Reset in the middle of a frame clears everything without a strobe.
      clear_frame();
      fr_re[20] = 999;
      send_frame(50, 1'b0, 0);
      @(negedge clk);
      bus.source_valid = 1'b0;
      rst_n            = 1'b0;
      tb_active        = 1'b0;
      @(negedge clk);
      chk("mid_rst_ready", 64'(bus.source_ready), 64'd0);
      chk("mid_rst_idx",   64'(peak_idx), 64'd0);
      chk("mid_rst_pwr",   64'(peak_pwr), 64'd0);
      rst_n = 1'b1;
      repeat (2) @(negedge clk);
      chk("mid_rst_pv", 64'(peak_valid | frame_err), 64'd0);
      clear_frame();
      fr_re[2] = 7;
      send_frame(FFT_N, 1'b1, 0);
      drain();

      chk("sb_empty", 64'(sb_q.size()), 64'd0);
      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule

// File: doc/fft_peak_detect.md
Name: fft_peak_detect

Overview:
- Sits directly downstream of the FFT core's Avalon-ST source port, in the same clock domain as the sink-side framing counter.
- Consumes one complex bin per valid beat, computes power = re² + im², and tracks the maximum-power bin across one N_POINTS frame.
- At frame end it emits the peak bin index and its power with a one-cycle strobe, and flags malformed frames.

Parameters:
- DATA_W, 16, signed width of source_real / source_imag
- N_POINTS, 512, FFT length; bins per frame
- IDX_W, 9, bin index width; must equal clog2(N_POINTS)

Ports:
- clk  in  1  system clock, rising edge
- rst_n  in  1  asynchronous active-low reset
- source_valid  in  1  FFT output beat valid
- source_sop  in  1  first bin of frame, qualified by source_valid
- source_eop  in  1  last bin of frame, qualified by source_valid
- source_real  in  DATA_W  signed real part
- source_imag  in  DATA_W  signed imaginary part
- source_ready  out  1  ready to FFT core; 0 in reset, 1 from the first clk edge after rst_n deasserts
- peak_idx  out  IDX_W  bin index of maximum power
- peak_pwr  out  2*DATA_W  unsigned maximum power
- peak_valid  out  1  one-cycle strobe; peak_idx/peak_pwr valid
- frame_err  out  1  one-cycle strobe on malformed frame

Behaviour:
- Interface: one clock, clk. Reset rst_n is asynchronous, active-low.
- Reset values: all outputs 0, FSM in IDLE, running max 0, bin counter 0, pipeline valids 0.
- Beat acceptance: a beat is accepted on a clk edge with source_valid=1 and source_ready=1. Beats with source_valid=0 are stalls; all state holds.
- FSM states:
  - IDLE: an accepted beat with sop=1 and eop=0 starts a frame. It loads bin 0 and goes to ACTIVE. An accepted beat with sop=0 is silently dropped, no error.
  - ACTIVE: each accepted beat increments the bin counter.
    - eop=1 with bin==N_POINTS-1: frame ends normally; return to IDLE.
    - eop=1 with bin!=N_POINTS-1: frame_err; return to IDLE; no peak_valid.
    - bin==N_POINTS-1 with eop=0: frame_err; return to IDLE.
    - sop=1 in ACTIVE: frame_err for the aborted frame, then restart at bin 0 with that beat, staying in ACTIVE.
  - sop=1 and eop=1 on the same beat: frame_err; state becomes IDLE.
- Pipeline:
  - Stage 1, edge k (beat accepted): register re², im² (signed multiply, unsigned results), bin index, last flag.
  - Stage 2, edge k+1: pwr = re² + im² in 2*DATA_W bits unsigned (max 2^31 at DATA_W=16, no overflow). Compare with the running max.
  - Latency: peak_valid is high in the cycle after edge k+1 for the eop beat accepted at edge k, i.e. 2 cycles.
- Compare rule:
  - Strict greater-than; on a tie the lower bin wins.
  - The first beat of a frame loads the max unconditionally.
  - An all-zero frame reports peak_idx=0, peak_pwr=0.
- Outputs: peak_idx/peak_pwr hold until the next peak_valid. frame_err and peak_valid are never high in the same cycle.
- Back-to-back frames: a new sop accepted on the edge right after an eop is legal. The pipeline must not mix the two frames.
- Reset mid-frame: everything is cleared, no strobe is emitted, and the FSM waits for the next sop.

Optional Feature:
- Macro: FFT_HALF_SPECTRUM_EN.
- Defined: only bins 0..N_POINTS/2-1 take part in the compare. Upper bins are still counted for framing and error checks.
- Undefined: all N_POINTS bins are compared.
- Latency and error behaviour are identical in both builds.

Decomposition:
- Package fft_pkg holds:
  - FFT_N=512
  - FFT_DATA_W=16
  - FFT_IDX_W=9
  - FFT_PWR_W=2*FFT_DATA_W
  - FSM state encoding (IDLE, ACTIVE)
- Sub-module fft_pwr_calc holds the stage-1 squaring registers and the stage-2 adder. It takes re/im/valid and returns pwr/valid, 2-cycle latency, and carries the sideband index and last flag.

Test Plan:
- Single frame, 512 beats, all zero except bin 37 with re=100, im=-200 -> peak_valid once, 2 cycles after eop; peak_idx=37, peak_pwr=50000.
- Tie: bins 10 and 300 both re=-32768, im=-32768 -> peak_idx=10, peak_pwr=2147483648.
- Short frame: eop at bin 200 -> frame_err pulse, no peak_valid. The next well-formed frame reports correctly.
- Mid-frame sop at bin 100, followed by a full 512-beat frame with peak at bin 5 -> one frame_err, then peak_idx=5.
- Back-to-back frames with random source_valid gaps (~30 % idle) and peaks at 3 then 400 -> two peak_valid strobes reporting 3 and 400.
- FFT_HALF_SPECTRUM_EN defined, largest bin at 400 and second largest at 100 -> peak_idx=100. Without the macro -> peak_idx=400.
